filt_decim_fifo: RTL and testbench

FILT_DECIM_FIFO -- requirements
Module: filt_decim_fifo

---
 rtl/filt_pkg.sv | 8 +
 rtl/filt_fifo.sv | 62 ++++++
 rtl/filt_decim_fifo.sv | 69 ++++++
 tb/tb_filt_decim_fifo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared constants for the decimating FIFO: default fixed-point split and the sample word type.
package filt_pkg;
  localparam int WIDTH_H_DEF = 5;
  localparam int WIDTH_W_DEF = 20;
  localparam int SAMPLE_W    = WIDTH_H_DEF + WIDTH_W_DEF;

  typedef logic [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/filt_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is accepted only
// when a pop happens on the same edge, otherwise it is reported on drop_o and discarded.
module filt_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 16,
  parameter int LOG_D = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req_i,
  input  logic [W-1:0]     data_i,
  input  logic             rd_req_i,
  output logic             data_o_en,
  output logic [W-1:0]     data_o,
  output logic [LOG_D:0]   count_o,
  output logic             drop_o
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [LOG_D-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LOG_D:0]   count_q, count_d;
  logic             empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (LOG_D+1)'(DEPTH));
  assign pop   = !empty && rd_req_i;
  // When full, the slot being written is the one being popped, so the old head is read out first.
  assign push  = wr_req_i && (!full || pop);

  assign data_o_en = !empty;
  assign data_o    = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign drop_o    = wr_req_i && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/filt_decim_fifo.sv
// Keeps every DECIM-th input sample and queues it in a FWFT FIFO.
// Define FILT_DECIM_OVF_EN to add the sticky ovf_o flag for samples dropped on a full FIFO.
module filt_decim_fifo
  import filt_pkg::*;
#(
  parameter int width_H   = WIDTH_H_DEF,
  parameter int width_W   = WIDTH_W_DEF,
  parameter int DECIM     = 4,
  parameter int DEPTH     = 16,
  parameter int log_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_i_en,
  input  logic [width_H+width_W-1:0] data_i,
  input  logic                       data_o_rdy,
  output logic                       data_o_en,
  output logic [width_H+width_W-1:0] data_o,
`ifdef FILT_DECIM_OVF_EN
  output logic                       ovf_o,
`endif
  output logic [log_DEPTH:0]         count_o
);
  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0] PH_MAX = PH_W'(DECIM - 1);

  logic [PH_W-1:0] phase_q, phase_d;
  logic            keep, drop;

  assign keep = data_i_en && (phase_q == '0);

  always_comb begin
    phase_d = phase_q;
    if (data_i_en) phase_d = (phase_q == PH_MAX) ? '0 : phase_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  filt_fifo #(
    .W     (width_H + width_W),
    .DEPTH (DEPTH),
    .LOG_D (log_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_req_i  (keep),
    .data_i    (data_i),
    .rd_req_i  (data_o_rdy),
    .data_o_en (data_o_en),
    .data_o    (data_o),
    .count_o   (count_o),
    .drop_o    (drop)
  );

`ifdef FILT_DECIM_OVF_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (!rst_n)    ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end
  assign ovf_o = ovf_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif
endmodule

// File: tb/tb_filt_decim_fifo.sv
// Directed bench: instance A (DECIM=4, DEPTH=16) and instance B (DECIM=1, DEPTH=4).
module tb_filt_decim_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // instance A
  logic        rst_a, en_a, rdy_a, oen_a;
  logic [24:0] din_a, dout_a;
  logic [4:0]  cnt_a;
  // instance B
  logic        rst_b, en_b, rdy_b, oen_b;
  logic [24:0] din_b, dout_b;
  logic [2:0]  cnt_b;
`ifdef FILT_DECIM_OVF_EN
  logic        ovf_a, ovf_b;
`endif

  filt_decim_fifo #(.DECIM(4), .DEPTH(16), .log_DEPTH(4)) u_a (
    .clk(clk), .rst_n(rst_a), .data_i_en(en_a), .data_i(din_a), .data_o_rdy(rdy_a),
    .data_o_en(oen_a), .data_o(dout_a),
`ifdef FILT_DECIM_OVF_EN
    .ovf_o(ovf_a),
`endif
    .count_o(cnt_a));

  filt_decim_fifo #(.DECIM(1), .DEPTH(4), .log_DEPTH(2)) u_b (
    .clk(clk), .rst_n(rst_b), .data_i_en(en_b), .data_i(din_b), .data_o_rdy(rdy_b),
    .data_o_en(oen_b), .data_o(dout_b),
`ifdef FILT_DECIM_OVF_EN
    .ovf_o(ovf_b),
`endif
    .count_o(cnt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic rst, input logic en, input logic [24:0] d, input logic rdy);
    @(negedge clk);
    rst_a = rst; en_a = en; din_a = d; rdy_a = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic rst, input logic en, input logic [24:0] d, input logic rdy);
    @(negedge clk);
    rst_b = rst; en_b = en; din_b = d; rdy_b = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string name, input logic e, input logic [24:0] d, input logic [4:0] c);
    chk({name, ".en"}, 32'(oen_a), 32'(e));
    chk({name, ".data"}, 32'(dout_a), 32'(d));
    chk({name, ".cnt"}, 32'(cnt_a), 32'(c));
  endtask

  task automatic chk_b(input string name, input logic e, input logic [24:0] d, input logic [2:0] c);
    chk({name, ".en"}, 32'(oen_b), 32'(e));
    chk({name, ".data"}, 32'(dout_b), 32'(d));
    chk({name, ".cnt"}, 32'(cnt_b), 32'(c));
  endtask

  typedef struct {
    logic        en;
    logic [24:0] din;
    logic        rdy;
    logic        exp_en;
    logic [24:0] exp_do;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // DECIM=4 stream 1..12 with ready held: only phase-0 samples appear, one cycle later
    tbl[0]  = '{1'b1, 25'd1,  1'b1, 1'b1, 25'd1, 5'd1};
    tbl[1]  = '{1'b1, 25'd2,  1'b1, 1'b0, 25'd0, 5'd0};
    tbl[2]  = '{1'b1, 25'd3,  1'b1, 1'b0, 25'd0, 5'd0};
    tbl[3]  = '{1'b1, 25'd4,  1'b1, 1'b0, 25'd0, 5'd0};
    tbl[4]  = '{1'b1, 25'd5,  1'b1, 1'b1, 25'd5, 5'd1};
    tbl[5]  = '{1'b1, 25'd6,  1'b1, 1'b0, 25'd0, 5'd0};
    tbl[6]  = '{1'b1, 25'd7,  1'b1, 1'b0, 25'd0, 5'd0};
    tbl[7]  = '{1'b1, 25'd8,  1'b1, 1'b0, 25'd0, 5'd0};
    tbl[8]  = '{1'b1, 25'd9,  1'b1, 1'b1, 25'd9, 5'd1};
    tbl[9]  = '{1'b1, 25'd10, 1'b1, 1'b0, 25'd0, 5'd0};
    tbl[10] = '{1'b1, 25'd11, 1'b1, 1'b0, 25'd0, 5'd0};
    tbl[11] = '{1'b1, 25'd12, 1'b1, 1'b0, 25'd0, 5'd0};

    rst_a = 1'b0; en_a = 1'b0; din_a = '0; rdy_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0; din_b = '0; rdy_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset_a", 1'b0, 25'd0, 5'd0);
    chk_b("reset_b", 1'b0, 25'd0, 3'd0);
`ifdef FILT_DECIM_OVF_EN
    chk("reset_ovf_b", 32'(ovf_b), 32'd0);
`endif

    // ---------- instance A: table ----------
    for (int i = 0; i < 12; i++) begin
      step_a(1'b1, tbl[i].en, tbl[i].din, tbl[i].rdy);
      chk_a($sformatf("decim4_v%0d", i), tbl[i].exp_en, tbl[i].exp_do, tbl[i].exp_cnt);
    end

    // ready while empty is ignored
    for (int i = 0; i < 10; i++) begin
      step_a(1'b1, 1'b0, 25'd0, 1'b1);
      chk_a($sformatf("empty_rdy_%0d", i), 1'b0, 25'd0, 5'd0);
    end

    // phase cleared by reset: 40 kept, 41 dropped, reset during 42, then 44 kept
    step_a(1'b1, 1'b1, 25'd40, 1'b0);
    chk_a("ph_keep40", 1'b1, 25'd40, 5'd1);
    step_a(1'b1, 1'b1, 25'd41, 1'b0);
    chk_a("ph_drop41", 1'b1, 25'd40, 5'd1);
    step_a(1'b0, 1'b1, 25'd42, 1'b1);
    chk_a("ph_reset", 1'b0, 25'd0, 5'd0);
    step_a(1'b1, 1'b1, 25'd44, 1'b0);
    chk_a("ph_after_rst", 1'b1, 25'd44, 5'd1);

    // ---------- instance B ----------
    // -1 in 25 bits passes through bit-exact
    step_b(1'b1, 1'b1, 25'h1FFFFFF, 1'b0);
    chk_b("neg1_push", 1'b1, 25'h1FFFFFF, 3'd1);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("neg1_pop", 1'b0, 25'd0, 3'd0);

    // overflow: 10..15 with ready low, 14 and 15 dropped
    for (int i = 0; i < 6; i++) begin
      step_b(1'b1, 1'b1, 25'(10 + i), 1'b0);
      chk_b($sformatf("fill_%0d", 10 + i), 1'b1, 25'd10, (i < 4) ? 3'(i + 1) : 3'd4);
`ifdef FILT_DECIM_OVF_EN
      chk($sformatf("ovf_%0d", 10 + i), 32'(ovf_b), (i < 4) ? 32'd0 : 32'd1);
`endif
    end
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("drain_11", 1'b1, 25'd11, 3'd3);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("drain_12", 1'b1, 25'd12, 3'd2);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("drain_13", 1'b1, 25'd13, 3'd1);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("drain_empty", 1'b0, 25'd0, 3'd0);

    // full with push and pop together: nothing lost
    for (int i = 0; i < 4; i++) step_b(1'b1, 1'b1, 25'(20 + i), 1'b0);
    chk_b("full_20_23", 1'b1, 25'd20, 3'd4);
    step_b(1'b1, 1'b1, 25'd24, 1'b1);
    chk_b("full_pushpop", 1'b1, 25'd21, 3'd4);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("fp_22", 1'b1, 25'd22, 3'd3);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("fp_23", 1'b1, 25'd23, 3'd2);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("fp_24", 1'b1, 25'd24, 3'd1);
    step_b(1'b1, 1'b0, 25'd0, 1'b1);
    chk_b("fp_empty", 1'b0, 25'd0, 3'd0);
`ifdef FILT_DECIM_OVF_EN
    chk("ovf_sticky", 32'(ovf_b), 32'd1);
`endif

    // push+pop at partial occupancy keeps count and order
    step_b(1'b1, 1'b1, 25'd50, 1'b0);
    step_b(1'b1, 1'b1, 25'd51, 1'b1);
    chk_b("mid_pushpop", 1'b1, 25'd51, 3'd1);

    // reset with 3 queued and a sample present
    step_b(1'b1, 1'b1, 25'd30, 1'b0);
    step_b(1'b1, 1'b1, 25'd31, 1'b0);
    chk_b("pre_reset", 1'b1, 25'd51, 3'd3);
    step_b(1'b0, 1'b1, 25'd33, 1'b0);
    chk_b("reset_busy", 1'b0, 25'd0, 3'd0);
`ifdef FILT_DECIM_OVF_EN
    chk("reset_ovf_clr", 32'(ovf_b), 32'd0);
`endif
    step_b(1'b1, 1'b1, 25'd34, 1'b0);
    chk_b("post_reset", 1'b1, 25'd34, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
